// File: rtl/seg_pkg.sv
// Shared constants and frame type for the 4-digit 7-segment scanner.
package seg_pkg;
  localparam int NDIG  = 4;
  localparam int DIG_W = 4;
  localparam logic [NDIG-1:0] AN_OFF = 4'b1111;

  typedef logic [NDIG-1:0][DIG_W-1:0] bcd_frame_t;

  // Active-low anode pattern enabling only digit idx.
  function automatic logic [NDIG-1:0] an_select(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction
endpackage

// File: rtl/seg_prescaler.sv
// Slot timer: counts 0..DIV-1, flags the last cycle of a slot and the guard window.
module seg_prescaler #(
  parameter int DIV   = 10,
  parameter int GUARD = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic in_guard
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GRD  = CW'(GUARD);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  assign tick     = (cnt == LAST);
  assign cnt_next = tick ? '0 : cnt + CW'(1);
  // Look-ahead: the consumer registers its anodes, so it needs the guard
  // state of the cycle that is about to start.
  assign in_guard = (cnt_next < GRD);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_next;
  end
endmodule

// File: rtl/seg_scan.sv
// Multiplexed 4-digit BCD scanner with frame-boundary commit and anode guard.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int GUARD      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic        load,
  output logic [3:0]  val,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        busy
);
  localparam int DIV = CLK_HZ / REFRESH_HZ;

  logic       tick;
  logic       in_guard;
  bcd_frame_t stage;
  bcd_frame_t disp;
  bcd_frame_t disp_next;
  logic       pend;
  logic [1:0] idx_next;
  logic       commit;
  logic [NDIG-1:0] blank;
  logic [3:0] an_next;

  seg_prescaler #(.DIV(DIV), .GUARD(GUARD)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .in_guard (in_guard)
  );

  assign idx_next = tick ? digit_idx + 2'd1 : digit_idx;
  assign commit   = tick && (digit_idx == 2'd3);

  // A load coinciding with the commit point goes straight to the display.
  always_comb begin
    disp_next = disp;
    if (commit) begin
      if (load)      disp_next = digits_in;
      else if (pend) disp_next = stage;
    end
  end

`ifdef SEG_SCAN_LZB_EN
  assign blank[0] = 1'b0;
  for (genvar gi = 1; gi < NDIG; gi++) begin : g_lzb
    assign blank[gi] = (disp_next[NDIG-1:gi] == '0);
  end
`else
  assign blank = '0;
`endif

  assign an_next = (in_guard || blank[idx_next]) ? AN_OFF : an_select(idx_next);
  assign busy    = pend;

  // Outputs are computed from next-state values so val/an/digit_idx move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_idx <= 2'd0;
      stage     <= '0;
      disp      <= '0;
      pend      <= 1'b0;
      val       <= 4'd0;
      an        <= AN_OFF;
    end else begin
      digit_idx <= idx_next;
      disp      <= disp_next;
      val       <= disp_next[idx_next];
      an        <= an_next;
      if (commit) begin
        pend <= 1'b0;
      end else if (load) begin
        stage <= digits_in;
        pend  <= 1'b1;
      end
    end
  end
endmodule
